// File: rtl/peak_detect_pkg.sv
// peak_detect_pkg: shared types and constants for the peak detector.
//   state_t  - detector FSM states (IDLE, HIGH)
//   evt_t    - event record {peak[7:0], width[7:0]}
//   SAT_MAX  - 8-bit saturation ceiling for width and drop counters
package peak_detect_pkg;
    typedef enum logic {IDLE = 1'b0, HIGH = 1'b1} state_t;
    typedef struct packed {
        logic [7:0] peak;
        logic [7:0] width;
    } evt_t;
    localparam logic [7:0] SAT_MAX = 8'd255;
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: first-word-fall-through event FIFO, DEPTH entries (power of two).
//   clk, reset       - clock, async active-high reset
//   push, wdata      - write request and event record
//   pop              - consume head (ignored when empty)
//   rdata            - head record, zero while empty
//   full, empty      - occupancy flags
module evt_fifo
    import peak_detect_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  evt_t wdata,
    input  logic pop,
    output evt_t rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    evt_t mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop = pop & ~empty;
    // A push into a full FIFO is accepted when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign rdata = empty ? '0 : mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + {{AW{1'b0}}, do_push};
            rp <= rp + {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/peak_detect.sv
// peak_detect: hysteresis pulse detector reporting {peak, width} events.
//   clk, reset            - clock, async active-high reset
//   din                   - moving-average window sum, one sample per cycle
//   thr_hi, thr_lo        - arm / release thresholds (live)
//   active                - high while a pulse is being tracked
//   evt_valid, evt_ready  - event FIFO handshake
//   evt_peak, evt_width   - head event fields
//   drop_cnt              - saturating count of events lost to a full FIFO
module peak_detect
    import peak_detect_pkg::*;
#(
    parameter int MIN_WIDTH = 2,
    parameter int SETTLE    = 6,
    parameter int DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic [7:0] thr_hi,
    input  logic [7:0] thr_lo,
    output logic       active,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_peak,
    output logic [7:0] evt_width,
    output logic [7:0] drop_cnt
);
    localparam int SW = $clog2(SETTLE + 2);
    state_t state, state_n;
    logic [SW-1:0] settle;
    logic [7:0] width, width_n, peak, peak_n;
    logic settled, push, full, empty;
    evt_t head;
    assign settled = settle >= SW'(SETTLE);
    always_comb begin
        state_n = state;
        width_n = width;
        peak_n = peak;
        push = 1'b0;
        if (settled) begin
            if (state == IDLE) begin
                if (din >= thr_hi) begin
                    state_n = HIGH;
                    width_n = 8'd1;
                    peak_n = din;
                end
            end else if (din >= thr_lo) begin
                width_n = (width == SAT_MAX) ? width : width + 8'd1;
                peak_n = (din > peak) ? din : peak;
            end else begin
                // Exit sample is excluded from the event; short pulses vanish.
                state_n = IDLE;
                push = width >= 8'(MIN_WIDTH);
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            settle <= '0;
            width <= '0;
            peak <= '0;
            drop_cnt <= '0;
        end else begin
            if (!settled) settle <= settle + 1'b1;
            state <= state_n;
            width <= width_n;
            peak <= peak_n;
            // Full implies a valid head, so evt_ready alone decides whether room frees up.
            if (push && full && !evt_ready && drop_cnt != SAT_MAX) drop_cnt <= drop_cnt + 8'd1;
        end
    end
    evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .wdata('{peak: peak, width: width}),
        .pop  (evt_ready),
        .rdata(head),
        .full (full),
        .empty(empty)
    );
    assign active = state == HIGH;
    assign evt_valid = ~empty;
    assign evt_peak = head.peak;
    assign evt_width = head.width;
endmodule

// File: tb/tb_peak_detect.sv
// tb_peak_detect: randomized + directed scoreboard bench for peak_detect.
module tb_peak_detect;
    localparam int MIN_WIDTH = 2;
    localparam int SETTLE = 6;
    localparam int DEPTH = 4;

    logic clk = 0, reset = 1;
    logic [7:0] din = 0, thr_hi = 20, thr_lo = 10;
    logic evt_ready = 0;
    logic active, evt_valid;
    logic [7:0] evt_peak, evt_width, drop_cnt;

    peak_detect #(.MIN_WIDTH(MIN_WIDTH), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .din(din), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .active(active), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_peak(evt_peak), .evt_width(evt_width), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    // Reference model: pulse samples collected whole, events computed at pulse end.
    logic [15:0] sbq[$];
    logic [7:0] pq[$];
    int m_occ = 0, m_drop = 0, m_settle = 0;
    bit m_in = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got peak %0d width %0d expected none", evt_peak, evt_width);
            end else begin
                logic [15:0] e;
                e = sbq.pop_front();
                chk("evt_peak", int'(evt_peak), int'(e[15:8]));
                chk("evt_width", int'(evt_width), int'(e[7:0]));
            end
        end
    end

    task automatic step(input logic [7:0] d, input logic r);
        bit pop, acc;
        int w, pk;
        din = d;
        evt_ready = r;
        @(negedge clk);
        chk("evt_valid", int'(evt_valid), int'(m_occ > 0));
        chk("active", int'(active), int'(m_in));
        chk("drop_cnt", int'(drop_cnt), m_drop);
        #1;
        pop = (m_occ > 0) && r;
        acc = 0;
        if (m_settle < SETTLE) m_settle++;
        else if (!m_in) begin
            if (d >= thr_hi) begin
                m_in = 1;
                pq.delete();
                pq.push_back(d);
            end
        end else if (d >= thr_lo) pq.push_back(d);
        else begin
            m_in = 0;
            w = (pq.size() > 255) ? 255 : pq.size();
            pk = 0;
            foreach (pq[i]) if (pq[i] > pk) pk = pq[i];
            if (w >= MIN_WIDTH) begin
                if (m_occ < DEPTH || pop) begin
                    sbq.push_back({8'(pk), 8'(w)});
                    acc = 1;
                end else if (m_drop < 255) m_drop++;
            end
        end
        m_occ = m_occ - int'(pop) + int'(acc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        m_occ = 0;
        m_drop = 0;
        m_in = 0;
        m_settle = 0;
        pq.delete();
        sbq.delete();
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_peak", int'(evt_peak), 0);
        chk("rst_evt_width", int'(evt_width), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_active", int'(active), 0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic settle_steps();
        for (int i = 0; i < SETTLE; i++) step(8'd0, 1'b1);
    endtask

    task automatic pulse(input logic r_body, input logic r_exit);
        step(8'd25, r_body);
        step(8'd30, r_body);
        step(8'd9, r_exit);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        // Settle window: high input must be ignored
        for (int i = 0; i < SETTLE; i++) step(8'd50, 1'b1);
        for (int i = 0; i < 4; i++) step(8'd0, 1'b1);
        // Basic pulse
        step(8'd5, 1'b1); step(8'd25, 1'b1); step(8'd40, 1'b1);
        step(8'd30, 1'b1); step(8'd12, 1'b1); step(8'd9, 1'b1);
        for (int i = 0; i < 3; i++) step(8'd0, 1'b1);
        // Glitch shorter than MIN_WIDTH
        step(8'd25, 1'b1); step(8'd9, 1'b1); step(8'd0, 1'b1);
        // Overflow then simultaneous push/pop while full
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(8'd0, 1'b1);
        // Width saturation
        for (int i = 0; i < 300; i++) step(8'd200, 1'b1);
        for (int i = 0; i < 3; i++) step(8'd0, 1'b1);
        // Reset mid-pulse with queued events
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        step(8'd25, 1'b0);
        step(8'd30, 1'b0);
        do_reset();
        settle_steps();
        for (int i = 0; i < 4; i++) step(8'd0, 1'b1);
        // Randomized traffic, inverted thresholds and occasional resets included
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                thr_hi = 8'($urandom_range(15, 40));
                thr_lo = 8'($urandom_range(5, 45));
            end
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                settle_steps();
            end
            step(8'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end
        thr_hi = 20;
        thr_lo = 10;
        for (int i = 0; i < 12; i++) step(8'd0, 1'b1);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
